fir_coeff_sample_ctrl: RTL and testbench
========================================

// Module: fir_coeff_sample_ctrl
// PURPOSE
//  Upstream control stage for the 33-tap transposed FIR multiply/add/shift datapath.
//  Paces 3-bit signed input samples to one per SAMPLE_DIV clocks and emits the matching accumulate-enable strobe.
//  Holds a shadow/active double-buffered bank of 33 x 16-bit signed coefficients.
//  Shadow->active commit occurs only on a sample boundary, so the datapath never mixes old and new taps within one sample.
// PARAMETERS
//  SAMPLE_DIV  12  clocks per output sample (12 MHz -> 1 MS/s); legal range >= 2
// PORTS
//  iClk_12M       in   1    single clock, 12 MHz
//  iRst           in   1    synchronous reset, active-high
//  iInValid       in   1    upstream sample valid
//  oInReady       out  1    sample accepted when iInValid && oInReady
//  iInData        in   3    signed input sample
//  iCoeffWe       in   1    shadow coefficient write strobe
//  iCoeffAddr     in   6    tap index 0..32 (0 = first tap / Coeff1)
//  iCoeffData     in   16   signed coefficient value
//  iCoeffCommit   in   1    request shadow->active copy at next sample tick
//  oCoeffPending  out  1    commit requested, not yet applied
//  oFirIn         out  3    signed sample to datapath
//  oEnAcc         out  1    one-cycle accumulate enable to datapath
//  oCoeff         out  528  active bank; tap k at [16k+15:16k]
//  oUnderflow     out  1    one-cycle pulse: tick with no sample held
//  oAddrErr       out  1    one-cycle pulse: write with addr > 32
// BEHAVIOUR
//  Reset (iRst=1 at edge): divider=0, buffer empty, shadow=active=0, pending=0.
//   Reset outputs: oFirIn=0, oEnAcc=0, oUnderflow=0, oAddrErr=0, oCoeffPending=0, oInReady=1.
//   Reset mid-operation discards the held sample and any pending commit.
//  Divider: counts 0..SAMPLE_DIV-1 and wraps. tick = (count == SAMPLE_DIV-1).
//  Input buffer: one entry.
//   oInReady = !full || tick (combinational).
//   Accept on a tick cycle: the new sample replaces the one being consumed; full stays 1.
//  Tick edge, registered (visible the cycle after tick):
//   oEnAcc=1.
//   oFirIn = held sample if full, else 3'sd0; empty buffer also sets oUnderflow=1.
//   Buffer consumed unless refilled in the same cycle.
//   Non-tick cycles: oEnAcc=0, oUnderflow=0; oFirIn holds its last value.
//   Exactly one oEnAcc pulse per SAMPLE_DIV clocks.
//  Coefficient write: iCoeffWe && addr <= 32 writes shadow[addr] at the edge.
//   addr 33..63: shadow unchanged; oAddrErr=1 the next cycle.
//  Commit:
//   iCoeffCommit sets pending; a commit while pending has no extra effect.
//   On a tick with pending=1: active <= shadow and pending <= 0.
//   The new oCoeff appears on the same edge oEnAcc rises, so it applies to that sample.
//   Tick and commit in the same cycle: pending set; the copy waits for the next tick.
//   Shadow write in the same cycle as the copy: the copy takes the pre-write shadow value.
//   The write lands in shadow only.
//  Active bank changes only on a committed tick; oCoeff is a direct register output with no comb path.
//  Arithmetic: no arithmetic on data; coefficients are stored and passed bit-exact.
// STRUCTURE
//  Shared package fir_pkg:
//   NUM_TAPS=33, COEFF_W=16, DATA_W=3, TAP_ADDR_W=6, COEFF_BUS_W=NUM_TAPS*COEFF_W.
//  Sub-module fir_sample_pacer: divider, one-entry buffer, oInReady, oEnAcc/oFirIn/oUnderflow regs.
//   It exports tick to the top level.
//  Top level: shadow/active banks, address check, pending flag.
// TESTING
//  1 Reset, no input, SAMPLE_DIV=12 -> oEnAcc pulses at cycles 12,24,36...; oFirIn=0; oUnderflow pulses with each.
//  2 Stream -3,2,1 with iInValid always 1 -> oFirIn sequence -3,2,1, one per oEnAcc.
//    oInReady high only on tick cycles once full; no underflow.
//  3 Write shadow[0]=16'sd100 and shadow[32]=-16'sd5, then commit mid-period.
//    -> oCoeff unchanged until the next tick edge, then [15:0]=100, [527:512]=0xFFFB, both with oEnAcc.
//    -> oCoeffPending high from commit to that edge.
//  4 Write addr=33 data=0x1234 -> oAddrErr one pulse, shadow and active unchanged after a commit.
//  5 Commit and shadow[5]=7 write in the same cycle as a tick -> copy deferred to the next tick.
//    -> The next tick copies 7.
//    Separately: write shadow[5]=9 on the copy tick with pending=1 -> active[5] takes the old shadow value.
//  6 iRst during a pending commit with a held sample -> pending=0, active=0.
//    -> First post-reset oEnAcc carries oFirIn=0 and oUnderflow.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR control slice.
//  NUM_TAPS    : number of coefficient taps in the datapath
//  COEFF_W     : coefficient width (signed)
//  DATA_W      : input sample width (signed)
//  TAP_ADDR_W  : coefficient address width
//  COEFF_BUS_W : width of the flattened active coefficient bus
package fir_pkg;

    localparam int unsigned NUM_TAPS    = 33;
    localparam int unsigned COEFF_W     = 16;
    localparam int unsigned DATA_W      = 3;
    localparam int unsigned TAP_ADDR_W  = 6;
    localparam int unsigned COEFF_BUS_W = NUM_TAPS * COEFF_W;

    typedef logic signed [COEFF_W-1:0] coeff_t;
    typedef logic signed [DATA_W-1:0]  sample_t;

endpackage

// File: rtl/fir_sample_pacer.sv
// Sample pacer: divides the clock to one sample slot per SAMPLE_DIV cycles,
// holds one upstream sample, and emits the registered datapath strobes.
//  i_clk, i_rst   : clock, synchronous active-high reset
//  i_in_valid     : upstream sample valid
//  o_in_ready     : sample accepted when valid && ready
//  i_in_data      : signed input sample
//  o_fir_in       : sample presented to the datapath (held between ticks)
//  o_en_acc       : one-cycle accumulate enable, the cycle after a tick
//  o_underflow    : one-cycle pulse when a tick found the buffer empty
//  o_tick         : combinational tick (last cycle of each sample period)
module fir_sample_pacer
    import fir_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    output logic [DATA_W-1:0] o_fir_in,
    output logic              o_en_acc,
    output logic              o_underflow,
    output logic              o_tick
);

    localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);

    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    sample_t           r_data;
    logic              w_tick;
    logic              w_accept;

    assign w_tick     = (r_count == CNT_W'(SAMPLE_DIV - 1));
    // On a tick the held sample is being consumed, so the slot is free again.
    assign o_in_ready = !r_full || w_tick;
    assign w_accept   = i_in_valid && o_in_ready;
    assign o_tick     = w_tick;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count     <= '0;
            r_full      <= 1'b0;
            r_data      <= '0;
            o_fir_in    <= '0;
            o_en_acc    <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            r_count <= w_tick ? '0 : r_count + CNT_W'(1);

            if (w_accept) begin
                r_data <= i_in_data;
            end

            if (w_tick) begin
                o_en_acc    <= 1'b1;
                o_fir_in    <= r_full ? r_data : '0;
                o_underflow <= !r_full;
                // Consumed this tick; stays full only if refilled now.
                r_full      <= w_accept;
            end else begin
                o_en_acc    <= 1'b0;
                o_underflow <= 1'b0;
                if (w_accept) begin
                    r_full <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fir_coeff_sample_ctrl.sv
// Upstream control for the 33-tap transposed FIR: paces samples and manages a
// shadow/active coefficient bank whose commit lands only on sample boundaries.
//  iClk_12M, iRst : clock, synchronous active-high reset
//  iInValid/oInReady/iInData : sample handshake and data
//  iCoeffWe/iCoeffAddr/iCoeffData : shadow coefficient write port
//  iCoeffCommit   : request shadow->active copy at the next tick
//  oCoeffPending  : commit requested but not yet applied
//  oFirIn, oEnAcc : sample and accumulate strobe to the datapath
//  oCoeff         : active bank, tap k at [16k+15:16k]
//  oUnderflow     : tick with no sample held
//  oAddrErr       : write to an address beyond the last tap
module fir_coeff_sample_ctrl
    import fir_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 12
) (
    input  logic                   iClk_12M,
    input  logic                   iRst,
    input  logic                   iInValid,
    output logic                   oInReady,
    input  logic [DATA_W-1:0]      iInData,
    input  logic                   iCoeffWe,
    input  logic [TAP_ADDR_W-1:0]  iCoeffAddr,
    input  logic [COEFF_W-1:0]     iCoeffData,
    input  logic                   iCoeffCommit,
    output logic                   oCoeffPending,
    output logic [DATA_W-1:0]      oFirIn,
    output logic                   oEnAcc,
    output logic [COEFF_BUS_W-1:0] oCoeff,
    output logic                   oUnderflow,
    output logic                   oAddrErr
);

    coeff_t                 r_shadow [NUM_TAPS];
    coeff_t                 r_active [NUM_TAPS];
    logic                   r_pending;
    logic                   r_addr_err;
    logic                   w_tick;
    logic                   w_addr_ok;
    logic [COEFF_BUS_W-1:0] w_coeff_bus;

    fir_sample_pacer #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_pacer (
        .i_clk       (iClk_12M),
        .i_rst       (iRst),
        .i_in_valid  (iInValid),
        .o_in_ready  (oInReady),
        .i_in_data   (iInData),
        .o_fir_in    (oFirIn),
        .o_en_acc    (oEnAcc),
        .o_underflow (oUnderflow),
        .o_tick      (w_tick)
    );

    assign w_addr_ok = (iCoeffAddr <= TAP_ADDR_W'(NUM_TAPS - 1));

    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            for (int unsigned k = 0; k < NUM_TAPS; k++) begin
                r_shadow[k] <= '0;
                r_active[k] <= '0;
            end
            r_pending  <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= iCoeffWe && !w_addr_ok;

            if (iCoeffWe && w_addr_ok) begin
                r_shadow[iCoeffAddr] <= iCoeffData;
            end

            // Copy reads the pre-edge shadow, so a same-cycle write only
            // lands in shadow. A commit arriving on a tick without pending
            // just arms the flag for the following tick.
            if (w_tick && r_pending) begin
                for (int unsigned k = 0; k < NUM_TAPS; k++) begin
                    r_active[k] <= r_shadow[k];
                end
                r_pending <= 1'b0;
            end else if (iCoeffCommit) begin
                r_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        w_coeff_bus = '0;
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
            w_coeff_bus[k*COEFF_W +: COEFF_W] = r_active[k];
        end
    end

    assign oCoeff        = w_coeff_bus;
    assign oCoeffPending = r_pending;
    assign oAddrErr      = r_addr_err;

endmodule

// File: tb/tb_fir_coeff_sample_ctrl.sv
// Directed bench for fir_coeff_sample_ctrl with SAMPLE_DIV=12.
module tb_fir_coeff_sample_ctrl;

    logic         clk = 1'b0;
    logic         iRst;
    logic         iInValid;
    logic         oInReady;
    logic [2:0]   iInData;
    logic         iCoeffWe;
    logic [5:0]   iCoeffAddr;
    logic [15:0]  iCoeffData;
    logic         iCoeffCommit;
    logic         oCoeffPending;
    logic [2:0]   oFirIn;
    logic         oEnAcc;
    logic [527:0] oCoeff;
    logic         oUnderflow;
    logic         oAddrErr;

    int           total = 0;
    int           bad   = 0;
    int unsigned  c     = 0;   // edges since reset release; c%12 == divider count
    logic [527:0] exp_bus;

    always #5 clk = ~clk;

    fir_coeff_sample_ctrl #(
        .SAMPLE_DIV (12)
    ) dut (
        .iClk_12M      (clk),
        .iRst          (iRst),
        .iInValid      (iInValid),
        .oInReady      (oInReady),
        .iInData       (iInData),
        .iCoeffWe      (iCoeffWe),
        .iCoeffAddr    (iCoeffAddr),
        .iCoeffData    (iCoeffData),
        .iCoeffCommit  (iCoeffCommit),
        .oCoeffPending (oCoeffPending),
        .oFirIn        (oFirIn),
        .oEnAcc        (oEnAcc),
        .oCoeff        (oCoeff),
        .oUnderflow    (oUnderflow),
        .oAddrErr      (oAddrErr)
    );

    task automatic chk(input string tag, input logic [527:0] obs, input logic [527:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (iRst) c = 0;
        else      c = c + 1;
        @(negedge clk);
    endtask

    // Advance until the next edge is a tick edge (divider at 11).
    task automatic run_to_tick();
        for (int i = 0; i < 12 && (c % 12) != 11; i++) step();
    endtask

    initial begin
        iRst = 1'b1; iInValid = 1'b0; iInData = '0;
        iCoeffWe = 1'b0; iCoeffAddr = '0; iCoeffData = '0; iCoeffCommit = 1'b0;
        exp_bus = '0;
        @(negedge clk);
        step(); step();

        // Reset state
        chk("rst_enacc",   528'(oEnAcc), 528'(0));
        chk("rst_firin",   528'(oFirIn), 528'(0));
        chk("rst_uflow",   528'(oUnderflow), 528'(0));
        chk("rst_addrerr", 528'(oAddrErr), 528'(0));
        chk("rst_pending", 528'(oCoeffPending), 528'(0));
        chk("rst_ready",   528'(oInReady), 528'(1));
        chk("rst_coeff",   oCoeff, 528'(0));
        iRst = 1'b0;

        // 1: idle, oEnAcc after the 12th edge with underflow
        repeat (11) step();
        chk("t1_enacc_pre", 528'(oEnAcc), 528'(0));
        step();
        chk("t1_enacc",  528'(oEnAcc), 528'(1));
        chk("t1_uflow",  528'(oUnderflow), 528'(1));
        chk("t1_firin",  528'(oFirIn), 528'(0));
        step();
        chk("t1_enacc_off", 528'(oEnAcc), 528'(0));
        chk("t1_uflow_off", 528'(oUnderflow), 528'(0));

        // 2: stream -3, 2, 1
        iInValid = 1'b1; iInData = 3'b101;
        step();
        chk("t2_ready_full", 528'(oInReady), 528'(0));
        run_to_tick();
        chk("t2_ready_tick", 528'(oInReady), 528'(1));
        iInData = 3'b010;
        step();
        chk("t2_enacc1", 528'(oEnAcc), 528'(1));
        chk("t2_firin1", 528'(oFirIn), 528'(3'b101));
        chk("t2_uflow1", 528'(oUnderflow), 528'(0));
        chk("t2_ready_after", 528'(oInReady), 528'(0));
        run_to_tick();
        iInData = 3'b001;
        step();
        chk("t2_firin2", 528'(oFirIn), 528'(3'b010));
        chk("t2_uflow2", 528'(oUnderflow), 528'(0));
        run_to_tick();
        iInValid = 1'b0;
        step();
        chk("t2_firin3", 528'(oFirIn), 528'(3'b001));
        chk("t2_uflow3", 528'(oUnderflow), 528'(0));
        step();
        chk("t2_firin_hold", 528'(oFirIn), 528'(3'b001));

        // 3: write taps 0 and 32, commit mid-period
        iCoeffWe = 1'b1; iCoeffAddr = 6'd0; iCoeffData = 16'd100;
        step();
        iCoeffAddr = 6'd32; iCoeffData = 16'hFFFB;
        step();
        iCoeffWe = 1'b0;
        iCoeffCommit = 1'b1;
        step();
        iCoeffCommit = 1'b0;
        chk("t3_pending",     528'(oCoeffPending), 528'(1));
        chk("t3_coeff_hold",  oCoeff, 528'(0));
        run_to_tick();
        chk("t3_pending_pre", 528'(oCoeffPending), 528'(1));
        chk("t3_coeff_pre",   oCoeff, 528'(0));
        step();
        exp_bus[15:0]    = 16'd100;
        exp_bus[527:512] = 16'hFFFB;
        chk("t3_enacc",       528'(oEnAcc), 528'(1));
        chk("t3_coeff",       oCoeff, exp_bus);
        chk("t3_pending_clr", 528'(oCoeffPending), 528'(0));

        // 4: out-of-range write
        step();
        iCoeffWe = 1'b1; iCoeffAddr = 6'd33; iCoeffData = 16'h1234;
        step();
        iCoeffWe = 1'b0;
        chk("t4_addrerr",     528'(oAddrErr), 528'(1));
        step();
        chk("t4_addrerr_off", 528'(oAddrErr), 528'(0));
        iCoeffCommit = 1'b1;
        step();
        iCoeffCommit = 1'b0;
        run_to_tick();
        step();
        chk("t4_coeff",   oCoeff, exp_bus);
        chk("t4_pending", 528'(oCoeffPending), 528'(0));

        // 5a: commit and write on a tick cycle -> copy deferred
        run_to_tick();
        iCoeffCommit = 1'b1; iCoeffWe = 1'b1; iCoeffAddr = 6'd5; iCoeffData = 16'd7;
        step();
        iCoeffCommit = 1'b0; iCoeffWe = 1'b0;
        chk("t5_pending_set", 528'(oCoeffPending), 528'(1));
        chk("t5_coeff_defer", oCoeff, exp_bus);
        run_to_tick();
        step();
        exp_bus[95:80] = 16'd7;
        chk("t5_coeff_copy",  oCoeff, exp_bus);
        chk("t5_pending_clr", 528'(oCoeffPending), 528'(0));

        // 5b: write on the copy tick -> active takes old shadow value
        step();
        iCoeffCommit = 1'b1;
        step();
        iCoeffCommit = 1'b0;
        run_to_tick();
        iCoeffWe = 1'b1; iCoeffAddr = 6'd5; iCoeffData = 16'd9;
        step();
        iCoeffWe = 1'b0;
        chk("t5b_coeff_old", oCoeff, exp_bus);
        chk("t5b_pending",   528'(oCoeffPending), 528'(0));
        iCoeffCommit = 1'b1;
        step();
        iCoeffCommit = 1'b0;
        run_to_tick();
        step();
        exp_bus[95:80] = 16'd9;
        chk("t5b_coeff_new", oCoeff, exp_bus);

        // 6: reset with a held sample and a pending commit
        step();
        iInValid = 1'b1; iInData = 3'b010;
        step();
        iInValid = 1'b0;
        iCoeffCommit = 1'b1;
        step();
        iCoeffCommit = 1'b0;
        chk("t6_pending_pre", 528'(oCoeffPending), 528'(1));
        chk("t6_ready_full",  528'(oInReady), 528'(0));
        iRst = 1'b1;
        step();
        iRst = 1'b0;
        chk("t6_pending", 528'(oCoeffPending), 528'(0));
        chk("t6_coeff",   oCoeff, 528'(0));
        chk("t6_ready",   528'(oInReady), 528'(1));
        repeat (11) step();
        chk("t6_enacc_pre", 528'(oEnAcc), 528'(0));
        step();
        chk("t6_enacc", 528'(oEnAcc), 528'(1));
        chk("t6_firin", 528'(oFirIn), 528'(0));
        chk("t6_uflow", 528'(oUnderflow), 528'(1));
        chk("t6_coeff_post", oCoeff, 528'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
